// File: rtl/respondedor_bus_datos.sv
// Data-side bus responder for the single-cycle core: word RAM plus an I/O page
// with LEDs, a sticky button latch and a prescaled timer with compare flag.
module respondedor_bus_datos #(
  parameter int          PALABRAS = 128,
  parameter logic [31:0] BASE_IO  = 32'h0000_1000,
  parameter int          PRESC    = 4,
  parameter int          NBOTONES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                memWr,
  input  logic                memRd,
  input  logic [31:0]         direc,
  input  logic [31:0]         datoEscr,
  input  logic [NBOTONES-1:0] botones,
  output logic [31:0]         datoLect,
  output logic [7:0]          leds,
  output logic                irqTimer
);

  localparam int          AW          = (PALABRAS > 1) ? $clog2(PALABRAS) : 1;
  localparam int          PW          = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [31:0] RAM_BYTES   = 32'(PALABRAS * 4);
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);
  localparam logic [29:0] A_BOTONES   = BASE_IO[31:2] + 30'd0;
  localparam logic [29:0] A_TIMER     = BASE_IO[31:2] + 30'd1;
  localparam logic [29:0] A_CMP       = BASE_IO[31:2] + 30'd2;
  localparam logic [29:0] A_STATUS    = BASE_IO[31:2] + 30'd3;
  localparam logic [29:0] A_LEDS      = BASE_IO[31:2] + 30'd4;

  logic [31:0]         mem_q [PALABRAS];
  logic [NBOTONES-1:0] sync1_q, sync2_q, sync3_q, latch_q, latch_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [31:0]         timer_q, timer_d, cmp_q, cmp_d;
  logic                status_q, status_d;
  logic [7:0]          leds_q, leds_d;

  logic          in_ram_s, sel_bot_s, sel_tim_s, sel_cmp_s, sel_sta_s, sel_led_s;
  logic          tick_s, match_s;
  logic [AW-1:0] ram_idx_s;
  logic [NBOTONES-1:0] rise_s;
  logic [31:0]   rd_s;

  assign in_ram_s  = (direc < RAM_BYTES);
  assign ram_idx_s = direc[AW+1:2];
  assign sel_bot_s = (direc[31:2] == A_BOTONES);
  assign sel_tim_s = (direc[31:2] == A_TIMER);
  assign sel_cmp_s = (direc[31:2] == A_CMP);
  assign sel_sta_s = (direc[31:2] == A_STATUS);
  assign sel_led_s = (direc[31:2] == A_LEDS);

  assign rise_s  = sync2_q & ~sync3_q;
  assign tick_s  = (presc_q == PRESC_MAX);
  // A TIMER store suppresses tick processing, including the compare match.
  assign match_s = tick_s & ~(memWr & sel_tim_s) & (timer_q == cmp_q);

  // RAM write port; contents survive reset, stores during reset are dropped
  always_ff @(posedge clk) begin
    if (memWr && !rst && in_ram_s) begin
      mem_q[ram_idx_s] <= datoEscr;
    end
  end

  // Same-cycle read mux; narrow fields zero-extend, unmapped reads give zero
  always_comb begin
    rd_s = 32'h0000_0000;
    if (in_ram_s) begin
      rd_s = mem_q[ram_idx_s];
    end else if (sel_bot_s) begin
      rd_s = 32'(latch_q);
    end else if (sel_tim_s) begin
      rd_s = timer_q;
    end else if (sel_cmp_s) begin
      rd_s = cmp_q;
    end else if (sel_sta_s) begin
      rd_s = {31'd0, status_q};
    end else if (sel_led_s) begin
      rd_s = {24'd0, leds_q};
    end else begin
      rd_s = 32'h0000_0000;
    end
  end

  // Next-state logic for the I/O page registers
  always_comb begin
    latch_d  = ((memRd && sel_bot_s) ? {NBOTONES{1'b0}} : latch_q) | rise_s;
    cmp_d    = (memWr && sel_cmp_s) ? datoEscr : cmp_q;
    leds_d   = (memWr && sel_led_s) ? datoEscr[7:0] : leds_q;
    timer_d  = timer_q;
    presc_d  = presc_q;
    status_d = status_q;
    if (memWr && sel_tim_s) begin
      timer_d = datoEscr;
      presc_d = {PW{1'b0}};
    end else begin
      presc_d = tick_s ? {PW{1'b0}} : presc_q + {{(PW-1){1'b0}}, 1'b1};
      if (match_s) begin
        timer_d = 32'h0000_0000;
      end else if (tick_s) begin
        timer_d = timer_q + 32'd1;
      end else begin
        timer_d = timer_q;
      end
    end
    // Match-set wins over a coincident write-one-to-clear.
    if (match_s) begin
      status_d = 1'b1;
    end else if (memWr && sel_sta_s && datoEscr[0]) begin
      status_d = 1'b0;
    end else begin
      status_d = status_q;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q  <= {NBOTONES{1'b0}};
      sync2_q  <= {NBOTONES{1'b0}};
      sync3_q  <= {NBOTONES{1'b0}};
      latch_q  <= {NBOTONES{1'b0}};
      presc_q  <= {PW{1'b0}};
      timer_q  <= 32'h0000_0000;
      cmp_q    <= 32'hFFFF_FFFF;
      status_q <= 1'b0;
      leds_q   <= 8'h00;
    end else begin
      sync1_q  <= botones;
      sync2_q  <= sync1_q;
      sync3_q  <= sync2_q;
      latch_q  <= latch_d;
      presc_q  <= presc_d;
      timer_q  <= timer_d;
      cmp_q    <= cmp_d;
      status_q <= status_d;
      leds_q   <= leds_d;
    end
  end

  assign datoLect = rd_s;
  assign leds     = leds_q;
  assign irqTimer = status_q;

endmodule

// File: tb/tb_respondedor_bus_datos.sv
// Directed bench for respondedor_bus_datos: expected values are queued as each
// step is driven and popped when the matching DUT output is sampled.
module tb_respondedor_bus_datos;

  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk, rst, memWr, memRd;
  logic [31:0] direc, datoEscr, datoLect;
  logic [3:0]  botones;
  logic [7:0]  leds;
  logic        irqTimer;

  logic [31:0] exp_q [$];
  int          vectors;
  int          miscompares;

  respondedor_bus_datos #(
    .PALABRAS(128), .BASE_IO(32'h0000_1000), .PRESC(4), .NBOTONES(4)
  ) dut (
    .clk(clk), .rst(rst), .memWr(memWr), .memRd(memRd), .direc(direc),
    .datoEscr(datoEscr), .botones(botones), .datoLect(datoLect),
    .leds(leds), .irqTimer(irqTimer)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    vectors++;
    if (exp_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s: observed %h but scoreboard empty", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, obs, e);
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    memWr = 1'b1; direc = a; datoEscr = d;
    step(1);
    memWr = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, input string tag, input logic [31:0] e);
    direc = a;
    #1;
    exp_q.push_back(e);
    check(tag, datoLect);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] obs, input logic [31:0] e);
    exp_q.push_back(e);
    check(tag, obs);
  endtask

  initial begin
    vectors = 0; miscompares = 0;
    rst = 1'b0; memWr = 1'b0; memRd = 1'b0; direc = 32'd0; datoEscr = 32'd0; botones = 4'd0;
    #1 rst = 1'b1;
    step(2);
    rst = 1'b0;

    // reset values
    chk_out("rst_leds", {24'd0, leds}, 32'h0);
    chk_out("rst_irq", {31'd0, irqTimer}, 32'h0);
    rd(BASE + 32'h0,  "rst_bot", 32'h0);
    rd(BASE + 32'h4,  "rst_timer", 32'h0);
    rd(BASE + 32'h8,  "rst_cmp", 32'hFFFF_FFFF);
    rd(BASE + 32'hC,  "rst_status", 32'h0);
    rd(BASE + 32'h10, "rst_ledsreg", 32'h0);

    // RAM
    wr(32'h8, 32'hDEAD_BEEF);
    rd(32'h8,   "ram_rd", 32'hDEAD_BEEF);
    rd(32'hB,   "ram_rd_unaligned", 32'hDEAD_BEEF);
    rd(32'h800, "unmapped_rd", 32'h0);
    memWr = 1'b1; direc = 32'h8; datoEscr = 32'h0000_0123;
    #1;
    exp_q.push_back(32'hDEAD_BEEF);
    check("ram_old_on_write", datoLect);
    step(1);
    memWr = 1'b0;
    rd(32'h8, "ram_new", 32'h0000_0123);

    // LEDS and asynchronous reset
    wr(BASE + 32'h10, 32'h0000_01A5);
    chk_out("leds_out", {24'd0, leds}, 32'hA5);
    rd(BASE + 32'h10, "leds_rd", 32'h0000_00A5);
    #2 rst = 1'b1;
    #1;
    chk_out("leds_async_rst", {24'd0, leds}, 32'h0);
    #1 rst = 1'b0;
    step(1);
    rd(32'h8, "ram_survives_rst", 32'h0000_0123);

    // unmapped write
    wr(BASE + 32'h10, 32'h0000_003C);
    wr(BASE + 32'h14, 32'hFFFF_FFFF);
    chk_out("unmap_leds", {24'd0, leds}, 32'h3C);
    rd(BASE + 32'h8, "unmap_cmp", 32'hFFFF_FFFF);
    rd(BASE + 32'hC, "unmap_status", 32'h0);
    rd(32'h8,        "unmap_ram", 32'h0000_0123);

    // buttons
    botones = 4'b0100;
    step(1); rd(BASE, "bot_edge1", 32'h0);
    step(1); rd(BASE, "bot_edge2", 32'h0);
    step(1); rd(BASE, "bot_edge3", 32'h4);
    memRd = 1'b1; direc = BASE;
    step(1);
    memRd = 1'b0;
    rd(BASE, "bot_clear", 32'h0);
    botones = 4'b0101;
    step(2); rd(BASE, "bot_pre_coinc", 32'h0);
    memRd = 1'b1; direc = BASE;
    step(1);
    memRd = 1'b0;
    rd(BASE, "bot_set_wins", 32'h1);

    // timer match
    wr(BASE + 32'h8, 32'd3);
    wr(BASE + 32'h4, 32'd0);
    for (int k = 1; k <= 3; k++) begin
      step(4);
      rd(BASE + 32'h4, "timer_count", 32'(k));
    end
    step(4);
    rd(BASE + 32'h4, "timer_match_zero", 32'h0);
    rd(BASE + 32'hC, "status_match", 32'h1);
    chk_out("irq_match", {31'd0, irqTimer}, 32'h1);
    wr(BASE + 32'hC, 32'h1);
    rd(BASE + 32'hC, "status_w1c", 32'h0);
    chk_out("irq_w1c", {31'd0, irqTimer}, 32'h0);
    step(14);
    rd(BASE + 32'h4, "timer_before_coinc", 32'd3);
    wr(BASE + 32'hC, 32'h1);
    rd(BASE + 32'hC, "status_set_wins", 32'h1);
    rd(BASE + 32'h4, "timer_coinc_zero", 32'h0);

    // load priority on tick edge, then wrap without match
    wr(BASE + 32'hC, 32'h1);
    rd(BASE + 32'hC, "status_clear2", 32'h0);
    wr(BASE + 32'h8, 32'hFFFF_FFFE);
    step(1);
    wr(BASE + 32'h4, 32'hFFFF_FFFF);
    rd(BASE + 32'h4, "timer_load_prio", 32'hFFFF_FFFF);
    step(3);
    rd(BASE + 32'h4, "timer_hold", 32'hFFFF_FFFF);
    step(1);
    rd(BASE + 32'h4, "timer_wrap", 32'h0);
    rd(BASE + 32'hC, "status_no_match", 32'h0);
    chk_out("irq_no_match", {31'd0, irqTimer}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/respondedor_bus_datos.md
Name: respondedor_bus_datos

Overview:
Data-side bus responder for the single-cycle ARM core. It answers the processor's load/store port (memWr, direc, written data) with word RAM plus a memory-mapped I/O page holding LEDs, a button latch, and a prescaled timer with compare flag. Reads return data in the same cycle, as the single-cycle datapath requires. Writes and all register updates take effect on the rising clock edge.

Parameters:
PALABRAS, 128, RAM depth in 32-bit words; PALABRAS*4 <= BASE_IO.
BASE_IO, 32'h0000_1000, base byte address of the I/O page.
PRESC, 4, timer prescaler period in clk cycles (>=1).
NBOTONES, 4, number of button inputs (1..32).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
memWr  in  1  store strobe from control unit; sampled on the clk edge.
memRd  in  1  load strobe; high when the core loads (selDiWr == 2'b10); used only for read side effects.
direc  in  32  byte address from ALU; bits [1:0] ignored.
datoEscr  in  32  store data (register A read port).
botones  in  NBOTONES  raw asynchronous push-button levels, active-high.
datoLect  out  32  combinational read data.
leds  out  8  LED register.
irqTimer  out  1  level copy of STATUS bit0.

Behaviour:
- Address map (word aligned, direc[1:0] ignored):
  - RAM: direc < PALABRAS*4; word index = direc[..:2].
  - BASE_IO+0x0 BOTONES (R).
  - +0x4 TIMER (R/W).
  - +0x8 CMP (R/W).
  - +0xC STATUS (R; W1C bit0).
  - +0x10 LEDS (R/W, bits [7:0]).
- Unmapped address: reads return 0; writes ignored.
- Reads: datoLect is combinational from direc and current state, valid in the same cycle, independent of memRd. Register fields narrower than 32 bits are zero-extended.
- RAM: write on the clk edge when memWr is high; not cleared by reset. A read of an address in the same cycle as a write to it returns the old data.
- Reset values (async, immediate on rst): leds=0, TIMER=0, CMP=32'hFFFF_FFFF, STATUS=0, prescaler=0, button latch=0, synchronizer flops=0. irqTimer=0.
- Buttons:
  - Each input passes a 2-flop synchronizer, then rising-edge detection on the synchronized signal.
  - A detected edge sets its sticky latch bit.
  - A clk edge with memRd=1 and address BOTONES clears all latch bits. On the same edge, a new edge detection sets its bit (set wins over clear).
  - Latency: input rise to latch bit readable = 3 clk edges.
- Prescaler: counts 0..PRESC-1 and wraps; a "tick" is asserted on the edge where it wraps.
- Timer, per edge, in priority order:
  1. memWr to TIMER: TIMER <= datoEscr, prescaler <= 0, no tick processing.
  2. tick and TIMER == CMP: TIMER <= 0, STATUS[0] <= 1.
  3. tick: TIMER <= TIMER + 1, wrapping modulo 2^32.
- CMP write: takes effect on the next edge; a match is evaluated against the registered CMP.
- STATUS:
  - Write with datoEscr[0]=1 clears bit0. Match-set on the same edge wins (bit stays 1).
  - Bits [31:1] read 0.
- LEDS write: leds <= datoEscr[7:0] on the edge; the output is registered.
- memWr with rst asserted: ignored.
- rst deasserted mid-operation: state resumes from reset values; no partial writes.

Test Plan:
- Reset then RAM write: rst pulse; memWr=1, direc=0x8, datoEscr=0xDEADBEEF, one edge; direc=0x8 -> datoLect=0xDEADBEEF. direc=0xB -> same value. direc=0x800 (unmapped) -> 0.
- LEDS: store 0x1A5 to BASE_IO+0x10 -> leds=0xA5 after the edge; read -> 0x000000A5. Assert rst asynchronously mid-cycle -> leds=0 immediately.
- Buttons: raise botones[2] -> BOTONES reads 0x4 from the 3rd edge on. Load with memRd=1 -> next cycle reads 0. Edge on botones[0] coincident with the clear -> reads 0x1.
- Timer match: PRESC=4, write CMP=3, write TIMER=0. TIMER reads 1,2,3 every 4 cycles. On the next tick TIMER=0, STATUS=1, irqTimer=1. W1C write -> STATUS=0. W1C coincident with a match -> STATUS stays 1.
- Timer load priority and wrap: write TIMER=0xFFFFFFFF on the tick edge -> TIMER=0xFFFFFFFF and the prescaler restarts. With CMP=0xFFFFFFFE, after PRESC cycles TIMER=0 with no flag (wrap, no match).
- Unmapped write: store to BASE_IO+0x14 -> all registers and RAM unchanged.
